map_sequencer: RTL and testbench
================================

# map_sequencer

Race-flow controller on the response side of the finish-line scoreboard. Consumes the scoreboard's `map_change` level and BCD `score` word, identifies which bot won the current map, and issues the flag-clear pulse that re-arms the scoreboard. It then advances the map index and handshakes the new map with the world-map loader, holding off detection until the bots have settled on the new map.

## Interface
- `NUM_MAPS`, 4: number of maps in the rotation, ≥2.
- `CLR_CYCLES`, 4: width of the `flag_clr` pulse in clocks, ≥1.
- `SETTLE_CYCLES`, 1_000_000: dead time after a map load before detection re-arms, ≥1.
- `clk`  in  1  system clock.
- `map_rst`  in  1  reset, asynchronous, active-high; clock clk.
- `map_change`  in  1  finish flag from the scoreboard; asynchronous to `clk`, level, held until cleared.
- `score`  in  16  {bot1 BCD[15:8], bot2 BCD[7:0]}; changes asynchronously.
- `bot_ready`  in  1  loader acknowledge for `map_load`.
- `map_sel`  out  $clog2(NUM_MAPS)  current map index.
- `map_load`  out  1  load request for `map_sel`, held until acknowledged.
- `flag_clr`  out  1  scoreboard flag-clear pulse.
- `race_active`  out  1  high only in ARMED.
- `winner`  out  2  result of the last finished map: 00 none, 01 bot1, 10 bot2, 11 tie.
- `race_done`  out  1  rotation complete.

## Operation
- `map_change` passes through a 2-flop synchronizer. A rising edge is the synchronized value high while its previous sample was low.
- States: LOAD, SETTLE, ARMED, CAPTURE, CLEAR, DONE. The reset state is LOAD.
- LOAD: `map_load`=1. Leave to SETTLE on the edge where `bot_ready`=1.
- SETTLE: a counter runs for `SETTLE_CYCLES` cycles, then the block goes to ARMED. `map_change` edges are ignored.
- ARMED: on entry, snapshot `score` into `score_snap`. A rising edge moves the block to CAPTURE. A level already high at entry does not trigger; a fresh low→high transition is required.
- CAPTURE: one cycle. Compare the twice-registered `score` with `score_snap`:
  - Upper byte changed sets `winner[0]`.
  - Lower byte changed sets `winner[1]`.
  - Neither changed gives 00.
  - `winner` is registered and holds until the next CAPTURE.
- CLEAR: `flag_clr`=1 for exactly `CLR_CYCLES` cycles.
  - If `map_sel`≠NUM_MAPS-1, increment `map_sel` and go to LOAD.
  - Otherwise see Configuration.
- DONE: `race_done`=1 and all other strobes are 0. Only `map_rst` leaves DONE.
- All outputs are registered.

## Timing
- Reset values: `map_sel`=0, `map_load`=0, `flag_clr`=0, `race_active`=0, `winner`=00, `race_done`=0.
- `map_load` rises on the first `clk` edge after `map_rst` deasserts.
- If `map_change` is stable high before edge k, the synchronizer is high at k+1 and the edge is detected at k+2, moving the block to CAPTURE. `winner` updates at k+3, and `flag_clr` is high from k+3 for `CLR_CYCLES` cycles.
- `map_sel` updates on the same edge that `map_load` rises.
- If `bot_ready` is already high when LOAD is entered, LOAD lasts 1 cycle.
- `map_rst` mid-operation: immediate return to reset values. The counter and snapshot are cleared.
- If `map_change` is still high after CLEAR (flags not cleared), there is no retrigger, because a new edge is required.

## Configuration
- `MAP_SEQ_WRAP_EN` defined: after the last map, `map_sel` wraps to 0 and the block goes to LOAD. `race_done` pulses high for 1 cycle concurrent with that LOAD entry.
- `MAP_SEQ_WRAP_EN` undefined: after the last map the block goes to DONE, and `map_sel` stays at NUM_MAPS-1.

## Structure
- Package `map_seq_pkg`: state enum `map_seq_state_t`; winner codes `WIN_NONE`, `WIN_BOT1`, `WIN_BOT2`, `WIN_TIE`.
- Sub-module `edge_sync`: 2-flop synchronizer plus rising-edge detect, with a `clk`/async reset.

## Test plan
Bench uses NUM_MAPS=3, CLR_CYCLES=4, SETTLE_CYCLES=8; `bot_ready` is tied high unless stated.
- Reset release → `map_load` high 1 cycle, `map_sel`=0; `race_active`=1 after 8 settle cycles.
- In ARMED, `score` 0x0000→0x0100, `map_change`↑ → `winner`=01, `flag_clr` high 4 cycles, `map_sel`=1.
- `score` 0x0100→0x0201 together with the edge → `winner`=11. `map_change` high during SETTLE, then held high into ARMED → no CAPTURE until it drops and rises again.
- `bot_ready` held low 20 cycles in LOAD → `map_load` stays high 20 cycles; SETTLE starts the cycle after `bot_ready`↑.
- Third map finished:
  - Without the macro: DONE, `race_done`=1, `map_sel`=2, further edges ignored.
  - With `MAP_SEQ_WRAP_EN`: `map_sel`=0 and a 1-cycle `race_done`.
- `map_rst` asserted mid-CLEAR → `flag_clr`=0 immediately, `map_sel`=0, `winner`=00.

Source files
------------

// File: rtl/map_seq_pkg.sv
// Shared types for the map sequencer: FSM state encoding, winner codes and
// the score-compare helper used when a finished map is captured.
package map_seq_pkg;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_DONE    = 3'd5
  } map_seq_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_BOT1 = 2'b01;
  localparam logic [1:0] WIN_BOT2 = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // A bot scored if its BCD byte moved since the arm-time snapshot.
  function automatic logic [1:0] win_code(input logic [15:0] now_v, input logic [15:0] snap_v);
    logic [1:0] code_v;
    code_v = WIN_NONE;
    if (now_v[15:8] != snap_v[15:8]) begin
      code_v = code_v | WIN_BOT1;
    end else begin
      code_v = code_v;
    end
    if (now_v[7:0] != snap_v[7:0]) begin
      code_v = code_v | WIN_BOT2;
    end else begin
      code_v = code_v;
    end
    return code_v;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a rising-edge strobe
// taken from the synchronized value and its previous sample.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;
  logic prev_d, prev_q;

  // Next-state of the synchronizer chain.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and history flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/map_sequencer.sv
// Race-flow controller: loads maps, waits for the finish flag, scores the
// winner and re-arms the scoreboard. MAP_SEQ_WRAP_EN restarts the rotation.
module map_sequencer
  import map_seq_pkg::*;
#(
  parameter int NUM_MAPS      = 4,
  parameter int CLR_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 1_000_000
) (
  input  logic                        clk,
  input  logic                        map_rst,
  input  logic                        map_change,
  input  logic [15:0]                 score,
  input  logic                        bot_ready,
  output logic [$clog2(NUM_MAPS)-1:0] map_sel,
  output logic                        map_load,
  output logic                        flag_clr,
  output logic                        race_active,
  output logic [1:0]                  winner,
  output logic                        race_done
);

  localparam int SEL_W   = $clog2(NUM_MAPS);
  localparam int CNT_MAX = (SETTLE_CYCLES > CLR_CYCLES) ? SETTLE_CYCLES : CLR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_MAPS - 1);

  map_seq_state_t   state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [SEL_W-1:0] map_sel_d, map_sel_q;
  logic [15:0]      score_s1_d, score_s1_q;
  logic [15:0]      score_s2_d, score_s2_q;
  logic [15:0]      score_snap_d, score_snap_q;
  logic [1:0]       winner_d, winner_q;
  logic             map_load_d, map_load_q;
  logic             flag_clr_d, flag_clr_q;
  logic             race_active_d, race_active_q;
  logic             race_done_d, race_done_q;
  logic             done_pulse_s;
  logic             chg_rise_s;

  edge_sync u_chg_sync (
    .clk  (clk),
    .rst  (map_rst),
    .din  (map_change),
    .rise (chg_rise_s)
  );

  // Next-state, counter, map index, capture and output decode.
  always_comb begin
    state_d      = state_q;
    map_sel_d    = map_sel_q;
    winner_d     = winner_q;
    done_pulse_s = 1'b0;
    score_s1_d   = score;
    score_s2_d   = score_s1_q;

    case (state_q)
      ST_LOAD: begin
        // Request is raised first; the acknowledge only counts once it is out.
        if (map_load_q && bot_ready) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_ARMED: begin
        if (chg_rise_s) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        winner_d = win_code(score_s2_q, score_snap_q);
        state_d  = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (cnt_q != CLR_LAST) begin
          state_d = ST_CLEAR;
        end else if (map_sel_q != SEL_LAST) begin
          map_sel_d = map_sel_q + SEL_W'(1);
          state_d   = ST_LOAD;
        end else begin
`ifdef MAP_SEQ_WRAP_EN
          map_sel_d    = {SEL_W{1'b0}};
          done_pulse_s = 1'b1;
          state_d      = ST_LOAD;
`else
          state_d      = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    cnt_d = ((state_d == state_q) && ((state_q == ST_SETTLE) || (state_q == ST_CLEAR)))
            ? cnt_q + CNT_W'(1) : {CNT_W{1'b0}};

    if ((state_d == ST_ARMED) && (state_q != ST_ARMED)) begin
      score_snap_d = score_s2_q;
    end else begin
      score_snap_d = score_snap_q;
    end

    map_load_d    = (state_d == ST_LOAD);
    flag_clr_d    = (state_d == ST_CLEAR);
    race_active_d = (state_d == ST_ARMED);
    race_done_d   = (state_d == ST_DONE) | done_pulse_s;
  end

  // All state and registered outputs.
  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      state_q       <= ST_LOAD;
      cnt_q         <= {CNT_W{1'b0}};
      map_sel_q     <= {SEL_W{1'b0}};
      score_s1_q    <= 16'h0000;
      score_s2_q    <= 16'h0000;
      score_snap_q  <= 16'h0000;
      winner_q      <= WIN_NONE;
      map_load_q    <= 1'b0;
      flag_clr_q    <= 1'b0;
      race_active_q <= 1'b0;
      race_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      map_sel_q     <= map_sel_d;
      score_s1_q    <= score_s1_d;
      score_s2_q    <= score_s2_d;
      score_snap_q  <= score_snap_d;
      winner_q      <= winner_d;
      map_load_q    <= map_load_d;
      flag_clr_q    <= flag_clr_d;
      race_active_q <= race_active_d;
      race_done_q   <= race_done_d;
    end
  end

  assign map_sel     = map_sel_q;
  assign map_load    = map_load_q;
  assign flag_clr    = flag_clr_q;
  assign race_active = race_active_q;
  assign winner      = winner_q;
  assign race_done   = race_done_q;

endmodule

// File: tb/tb_map_sequencer.sv
// Scoreboard bench for map_sequencer: expected winner/next-map pairs are queued
// when a finish is stimulated and checked when the flag-clear pulse appears.
module tb_map_sequencer;

  localparam int NUM_MAPS      = 3;
  localparam int CLR_CYCLES    = 4;
  localparam int SETTLE_CYCLES = 8;

  logic        clk = 1'b0;
  logic        map_rst;
  logic        map_change;
  logic [15:0] score;
  logic        bot_ready;
  logic [1:0]  map_sel;
  logic        map_load;
  logic        flag_clr;
  logic        race_active;
  logic [1:0]  winner;
  logic        race_done;

  typedef struct {
    logic [1:0] win;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  map_sequencer #(
    .NUM_MAPS      (NUM_MAPS),
    .CLR_CYCLES    (CLR_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk         (clk),
    .map_rst     (map_rst),
    .map_change  (map_change),
    .score       (score),
    .bot_ready   (bot_ready),
    .map_sel     (map_sel),
    .map_load    (map_load),
    .flag_clr    (flag_clr),
    .race_active (race_active),
    .winner      (winner),
    .race_done   (race_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return race_active;
      1:       return flag_clr;
      2:       return race_done;
      default: return map_load;
    endcase
  endfunction

  // Bounded wait on a DUT output; returns the number of falling edges taken.
  task automatic wait_until(input string tag, input int which, input logic want,
                            input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((probe(which) !== want) && (cyc < bound));
    chk({tag, "_seen"}, probe(which), want);
  endtask

  task automatic push_exp(input logic [1:0] win, input logic [1:0] sel);
    exp_t e;
    e.win = win;
    e.sel = sel;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: pops on each flag_clr rise, checks width and next map.
  initial begin : monitor
    logic prev;
    int   width;
    exp_t cur;
    prev    = 1'b0;
    width   = 0;
    cur.win = 2'b00;
    cur.sel = 2'b00;
    forever begin
      @(negedge clk);
      if (map_rst) begin
        exp_q.delete();
        prev  = 1'b0;
        width = 0;
      end else begin
        if (flag_clr && !prev) begin
          chk("sb_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("winner", winner, cur.win);
          end
          width = 0;
        end
        if (flag_clr) width++;
        if (!flag_clr && prev) begin
          chk("clr_width", width, CLR_CYCLES);
          chk("sel_after_clr", map_sel, cur.sel);
        end
        prev = flag_clr;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    int highs;
    map_rst    = 1'b1;
    map_change = 1'b0;
    score      = 16'h0000;
    bot_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", map_sel, 0);
    chk("rst_load", map_load, 0);
    chk("rst_clr", flag_clr, 0);
    chk("rst_active", race_active, 0);
    chk("rst_winner", winner, 0);
    chk("rst_done", race_done, 0);

    map_rst = 1'b0;
    @(negedge clk);
    chk("load_rise", map_load, 1);
    chk("sel0", map_sel, 0);
    @(negedge clk);
    chk("load_1cyc", map_load, 0);
    wait_until("armed0", 0, 1'b1, 50, cyc);
    chk("settle_len", cyc, SETTLE_CYCLES);

    // Map 0: bot1 scores.
    score      = 16'h0100;
    map_change = 1'b1;
    push_exp(2'b01, 2'd1);
    wait_until("clr0", 1, 1'b1, 20, cyc);
    chk("trig_lat", cyc, 4);
    wait_until("clr0_end", 1, 1'b0, 20, cyc);
    chk("load1", map_load, 1);
    map_change = 1'b0;

    // Map 1: level raised during SETTLE must not trigger; then a tie.
    repeat (2) @(negedge clk);
    map_change = 1'b1;
    wait_until("armed1", 0, 1'b1, 30, cyc);
    repeat (10) @(negedge clk);
    chk("held_no_trig", race_active, 1);
    chk("held_winner", winner, 2'b01);
    map_change = 1'b0;
    repeat (4) @(negedge clk);
    score      = 16'h0201;
    map_change = 1'b1;
    push_exp(2'b11, 2'd2);
    wait_until("clr1", 1, 1'b1, 20, cyc);
    bot_ready = 1'b0;
    wait_until("clr1_end", 1, 1'b0, 20, cyc);

    // Map 2: loader stalls 20 cycles; flag still high from map 1.
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      highs += int'(map_load);
    end
    chk("load_hold", highs, 20);
    bot_ready = 1'b1;
    @(negedge clk);
    chk("load_ack", map_load, 0);
    wait_until("armed2", 0, 1'b1, 30, cyc);
    chk("settle_after_ack", cyc, SETTLE_CYCLES);
    repeat (10) @(negedge clk);
    chk("stale_level", race_active, 1);
    map_change = 1'b0;
    repeat (4) @(negedge clk);
    score      = 16'h0200;
    map_change = 1'b1;
`ifdef MAP_SEQ_WRAP_EN
    push_exp(2'b10, 2'd0);
`else
    push_exp(2'b10, 2'd2);
`endif
    wait_until("clr2", 1, 1'b1, 20, cyc);
    wait_until("clr2_end", 1, 1'b0, 20, cyc);

`ifdef MAP_SEQ_WRAP_EN
    chk("wrap_done", race_done, 1);
    chk("wrap_load", map_load, 1);
    chk("wrap_sel", map_sel, 0);
    @(negedge clk);
    chk("wrap_done_pulse", race_done, 0);
`else
    chk("done", race_done, 1);
    chk("done_sel", map_sel, 2);
    chk("done_load", map_load, 0);
    chk("done_active", race_active, 0);
    map_change = 1'b0;
    repeat (4) @(negedge clk);
    map_change = 1'b1;
    repeat (12) @(negedge clk);
    chk("done_hold", race_done, 1);
    chk("done_no_arm", race_active, 0);
    chk("done_winner", winner, 2'b10);
`endif

    // Reset in the middle of CLEAR.
    map_rst = 1'b1;
    repeat (2) @(negedge clk);
    map_change = 1'b0;
    map_rst    = 1'b0;
    wait_until("armed_r", 0, 1'b1, 40, cyc);
    score      = 16'h0300;
    map_change = 1'b1;
    push_exp(2'b01, 2'd1);
    wait_until("clr_r", 1, 1'b1, 20, cyc);
    @(negedge clk);
    #2;
    map_rst = 1'b1;
    #1;
    chk("midrst_clr", flag_clr, 0);
    chk("midrst_sel", map_sel, 0);
    chk("midrst_winner", winner, 0);
    chk("midrst_load", map_load, 0);
    repeat (3) @(negedge clk);
    map_rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
